// File: rtl/operand_gen_fwd.sv
// ID-stage operand generator: decodes op/funct/imm into two ALU operands with multi-stage
// bypassing, load-use stall detection and a valid/ready ID/EX output register.
module operand_gen_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter int FWD_NUM  = 2,
    parameter int STALL_CW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [5:0]                  op,
    input  logic [5:0]                  funct,
    input  logic [15:0]                 imm,
    input  logic [REG_AW-1:0]           rs_addr,
    input  logic [REG_AW-1:0]           rt_addr,
    input  logic [DATA_W-1:0]           reg_data_1,
    input  logic [DATA_W-1:0]           reg_data_2,
    input  logic [FWD_NUM-1:0]          fwd_wen,
    input  logic [FWD_NUM*REG_AW-1:0]   fwd_addr,
    input  logic [FWD_NUM*DATA_W-1:0]   fwd_data,
    input  logic [FWD_NUM-1:0]          fwd_pending,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           operand_1,
    output logic [DATA_W-1:0]           operand_2,
    output logic [STALL_CW-1:0]         stall_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [2:0] {
        OP2_ZERO,
        OP2_RT,
        OP2_SEXT,
        OP2_ZEXT,
        OP2_LUI
    } op2_sel_e;

    logic                   sel1_rs, sel1_link;
    op2_sel_e               op2_sel;
    logic                   use_rs, use_rt, stall;
    logic [DATA_W:0]        rs_byp, rt_byp;
    logic [ADDR_W-1:0]      link_addr;
    logic [DATA_W-1:0]      op1_val, op2_val;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]      operand_1_q, operand_1_d;
    logic [DATA_W-1:0]      operand_2_q, operand_2_d;
    logic [STALL_CW-1:0]    stall_cnt_q, stall_cnt_d;

    // Returns {pending, data}; the youngest matching source wins even if it is still pending.
    function automatic logic [DATA_W:0] bypass(input logic [REG_AW-1:0] idx,
                                               input logic [DATA_W-1:0] rf_data);
        logic            hit;
        logic [DATA_W:0] res;
        hit = 1'b0;
        res = {1'b0, rf_data};
        for (int i = 0; i < FWD_NUM; i++) begin
            if (!hit && fwd_wen[i] && fwd_addr[i*REG_AW +: REG_AW] == idx) begin
                hit = 1'b1;
                res = {fwd_pending[i], fwd_data[i*DATA_W +: DATA_W]};
            end
        end
        if (idx == '0) res = '0;
        return res;
    endfunction

    always_comb begin
        sel1_rs   = 1'b0;
        sel1_link = 1'b0;
        op2_sel   = OP2_ZERO;
        case (op)
            OP_SPECIAL: begin
                if (funct == FN_JALR) sel1_link = 1'b1;
                else                  sel1_rs   = 1'b1;
                op2_sel = OP2_RT;
            end
            OP_JAL: sel1_link = 1'b1;
            OP_ADDIU, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: begin
                sel1_rs = 1'b1;
                op2_sel = OP2_SEXT;
            end
            OP_ANDI, OP_ORI: begin
                sel1_rs = 1'b1;
                op2_sel = OP2_ZEXT;
            end
            OP_LUI: begin
                sel1_rs = 1'b1;
                op2_sel = OP2_LUI;
            end
            default: ;
        endcase
    end

    assign use_rs    = sel1_rs;
    assign use_rt    = (op2_sel == OP2_RT);
    assign rs_byp    = bypass(rs_addr, reg_data_1);
    assign rt_byp    = bypass(rt_addr, reg_data_2);
    assign link_addr = addr + ADDR_W'(8);

    always_comb begin
        op1_val = '0;
        if (sel1_link)    op1_val = DATA_W'(link_addr);
        else if (sel1_rs) op1_val = rs_byp[DATA_W-1:0];
        op2_val = '0;
        case (op2_sel)
            OP2_RT:   op2_val = rt_byp[DATA_W-1:0];
            OP2_SEXT: op2_val = DATA_W'(signed'(imm));
            OP2_ZEXT: op2_val = DATA_W'(imm);
            OP2_LUI:  op2_val = DATA_W'(imm) << 16;
            default:  op2_val = '0;
        endcase
    end

    // Unused operand fields never stall, even if their index matches a pending load.
    assign stall    = in_valid && ((use_rs && rs_byp[DATA_W]) || (use_rt && rt_byp[DATA_W]));
    assign in_ready = !stall && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        operand_1_d = operand_1_q;
        operand_2_d = operand_2_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_d = 1'b1;
            operand_1_d = op1_val;
            operand_2_d = op2_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (stall && !flush && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            operand_1_q <= '0;
            operand_2_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            operand_1_q <= operand_1_d;
            operand_2_q <= operand_2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign operand_1 = operand_1_q;
    assign operand_2 = operand_2_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_gen_fwd.sv
// Directed testbench for operand_gen_fwd: decode, bypass priority, load-use stalls,
// backpressure, flush, async reset and stall counter saturation.
module tb_operand_gen_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] reg_data_1;
    logic [31:0] reg_data_2;
    logic [1:0]  fwd_wen;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_pending;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    operand_gen_fwd dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .op(op), .funct(funct), .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .fwd_wen(fwd_wen),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
        .out_valid(out_valid), .out_ready(out_ready), .operand_1(operand_1),
        .operand_2(operand_2), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; addr = '0; op = '0; funct = '0; imm = '0;
        rs_addr = '0; rt_addr = '0; reg_data_1 = '0; reg_data_2 = '0;
        fwd_wen = '0; fwd_addr = '0; fwd_data = '0; fwd_pending = '0; out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (operand_1 !== 32'h0) begin n_fail++; $display("FAIL reset_op1 got %h exp 0", operand_1); end
        n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL reset_op2 got %h exp 0", operand_2); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        rst = 1;
        tick();
        $display("reset: valid=%b op1=%h op2=%h cnt=%h", out_valid, operand_1, operand_2, stall_cnt);
    endtask

    task automatic test_immediates();
        // ORI: zero-extended immediate
        clear_inputs();
        in_valid = 1; op = 6'h0D; rs_addr = 5'd3; reg_data_1 = 32'h1234_0000; imm = 16'h8001;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ori_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ori_valid got %b exp 1", out_valid); end
        n_checks++; if (operand_1 !== 32'h1234_0000) begin n_fail++; $display("FAIL ori_op1 got %h exp 12340000", operand_1); end
        n_checks++; if (operand_2 !== 32'h0000_8001) begin n_fail++; $display("FAIL ori_op2 got %h exp 00008001", operand_2); end
        $display("ori: op1=%h op2=%h", operand_1, operand_2);
        // ADDIU: sign-extended immediate
        in_valid = 1; op = 6'h09; rs_addr = 5'd2; reg_data_1 = 32'h10; imm = 16'hFFFF;
        tick();
        n_checks++; if (operand_1 !== 32'h10) begin n_fail++; $display("FAIL addiu_op1 got %h exp 10", operand_1); end
        n_checks++; if (operand_2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addiu_op2 got %h exp ffffffff", operand_2); end
        $display("addiu: op1=%h op2=%h", operand_1, operand_2);
        // LUI: immediate in the upper half
        op = 6'h0F; rs_addr = 5'd4; reg_data_1 = 32'h77; imm = 16'hABCD;
        tick();
        in_valid = 0;
        n_checks++; if (operand_1 !== 32'h77) begin n_fail++; $display("FAIL lui_op1 got %h exp 77", operand_1); end
        n_checks++; if (operand_2 !== 32'hABCD_0000) begin n_fail++; $display("FAIL lui_op2 got %h exp abcd0000", operand_2); end
        $display("lui: op1=%h op2=%h", operand_1, operand_2);
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        in_valid = 1; op = 6'h00; funct = 6'h21; rs_addr = 5'd5; rt_addr = 5'd5;
        reg_data_1 = 32'h111; reg_data_2 = 32'h222;
        fwd_wen = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hB, 32'hA};
        tick();
        n_checks++; if (operand_1 !== 32'hA) begin n_fail++; $display("FAIL prio_op1 got %h exp a", operand_1); end
        n_checks++; if (operand_2 !== 32'hA) begin n_fail++; $display("FAIL prio_op2 got %h exp a", operand_2); end
        $display("fwd prio: op1=%h op2=%h", operand_1, operand_2);
        // only older source enabled; rt on a different index reads the regfile
        fwd_wen = 2'b10; rt_addr = 5'd6;
        tick();
        in_valid = 0;
        n_checks++; if (operand_1 !== 32'hB) begin n_fail++; $display("FAIL fwd1_op1 got %h exp b", operand_1); end
        n_checks++; if (operand_2 !== 32'h222) begin n_fail++; $display("FAIL fwd1_op2 got %h exp 222", operand_2); end
        $display("fwd older: op1=%h op2=%h", operand_1, operand_2);
    endtask

    task automatic test_load_use();
        clear_inputs();
        in_valid = 1; op = 6'h00; funct = 6'h21; rs_addr = 5'd7; rt_addr = 5'd8;
        reg_data_1 = 32'h1; reg_data_2 = 32'h2;
        fwd_wen = 2'b01; fwd_addr = {5'd0, 5'd7}; fwd_pending = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready%0d got %b exp 0", c, in_ready); end
            tick();
        end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_cnt got %0d exp 2", stall_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", out_valid); end
        // load data arrives: forwarded value used with no further stall
        fwd_pending = 2'b00; fwd_data = {32'h0, 32'h55};
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b exp 1", in_ready); end
        tick();
        n_checks++; if (operand_1 !== 32'h55) begin n_fail++; $display("FAIL lu_op1 got %h exp 55", operand_1); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_cnt_hold got %0d exp 2", stall_cnt); end
        $display("load-use: op1=%h cnt=%0d", operand_1, stall_cnt);
        // a pending older source is shadowed by a ready younger one
        fwd_wen = 2'b11; fwd_addr = {5'd7, 5'd7}; fwd_pending = 2'b10;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL shadow_ready got %b exp 1", in_ready); end
        // a pending younger source shadows a ready older one
        fwd_pending = 2'b01;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL shadow_stall got %b exp 0", in_ready); end
        // ORI ignores rt, so a pending match on rt does not stall
        op = 6'h0D; rs_addr = 5'd9; rt_addr = 5'd7;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unused_rt got %b exp 1", in_ready); end
        in_valid = 0;
        tick();
        $display("shadow/unused checks done");
    endtask

    task automatic test_jal();
        clear_inputs();
        in_valid = 1; op = 6'h03; addr = 32'h0040_0010;
        fwd_wen = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_pending = 2'b01; fwd_data = {32'h0, 32'hDEAD};
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL jal_ready got %b exp 1", in_ready); end
        tick();
        n_checks++; if (operand_1 !== 32'h0040_0018) begin n_fail++; $display("FAIL jal_op1 got %h exp 00400018", operand_1); end
        n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL jal_op2 got %h exp 0", operand_2); end
        $display("jal: op1=%h op2=%h", operand_1, operand_2);
        // JALR with rs=rt=0 against a pending index-0 source
        op = 6'h00; funct = 6'h09; addr = 32'h0000_0100; reg_data_2 = 32'h1234;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL jalr_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        n_checks++; if (operand_1 !== 32'h0000_0108) begin n_fail++; $display("FAIL jalr_op1 got %h exp 00000108", operand_1); end
        n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL jalr_op2 got %h exp 0", operand_2); end
        $display("jalr: op1=%h op2=%h", operand_1, operand_2);
    endtask

    task automatic test_back_pressure();
        clear_inputs();
        in_valid = 1; op = 6'h0D; rs_addr = 5'd1; reg_data_1 = 32'hCAFE_0000; imm = 16'h00BE;
        tick();
        out_ready = 0; reg_data_1 = 32'h1111_1111; imm = 16'h2222;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b exp 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b exp 1", out_valid); end
        n_checks++; if (operand_1 !== 32'hCAFE_0000) begin n_fail++; $display("FAIL bp_op1 got %h exp cafe0000", operand_1); end
        n_checks++; if (operand_2 !== 32'h0000_00BE) begin n_fail++; $display("FAIL bp_op2 got %h exp 000000be", operand_2); end
        $display("backpressure: valid=%b op1=%h", out_valid, operand_1);
        // flush beats a simultaneous accept
        flush = 1; out_ready = 1;
        tick();
        flush = 0; in_valid = 0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        n_checks++; if (operand_1 !== 32'hCAFE_0000) begin n_fail++; $display("FAIL flush_op1 got %h exp cafe0000", operand_1); end
        $display("flush: valid=%b op1=%h", out_valid, operand_1);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        in_valid = 1; op = 6'h0D; rs_addr = 5'd1; reg_data_1 = 32'h5A5A_0000; imm = 16'h1;
        tick();
        in_valid = 0;
        #2 rst = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", out_valid); end
        n_checks++; if (operand_1 !== 32'h0) begin n_fail++; $display("FAIL arst_op1 got %h exp 0", operand_1); end
        n_checks++; if (operand_2 !== 32'h0) begin n_fail++; $display("FAIL arst_op2 got %h exp 0", operand_2); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_cnt got %h exp 0", stall_cnt); end
        $display("async reset: valid=%b op1=%h cnt=%h", out_valid, operand_1, stall_cnt);
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        in_valid = 1; op = 6'h00; funct = 6'h21; rs_addr = 5'd3; rt_addr = 5'd4;
        fwd_wen = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_pending = 2'b01;
        flush = 1;
        tick();
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL flush_cnt got %h exp 0", stall_cnt); end
        flush = 0;
        for (int k = 0; k < 65535; k++) @(posedge clk);
        #1;
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp ffff", stall_cnt); end
        tick();
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
        $display("saturation: cnt=%h", stall_cnt);
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_fwd_priority();
        test_load_use();
        test_jal();
        test_back_pressure();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
